// File: rtl/regbank_write_scheduler.sv
// Round-robin write-port scheduler for the 16-entry register bank.
// Drives the one-hot decoder's level-sensitive wclk with a setup/strobe/hold sequence.
module regbank_write_scheduler #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [4*NREQ-1:0]  req_addr,
  input  logic [DW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic [3:0]         address,
  output logic               wclk,
  output logic [DW-1:0]      wdata,
  output logic               busy,
  output logic [3:0]         grant_id
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] LAST = 4'(NREQ - 1);

  state_t          state;
  logic [3:0]      ptr;
  logic [3:0]      addr_a [16];
  logic [DW-1:0]   data_a [16];
  logic [NREQ-1:0] cur_mask;
  logic [4:0]      pick_idle;
  logic [4:0]      pick_hold;

  // Search from p upward, wrapping modulo NREQ; result is {found, index}.
  function automatic logic [4:0] rr_pick(input logic [NREQ-1:0] r, input logic [3:0] p);
    logic [15:0] r16;
    logic [4:0]  j;
    logic        found;
    logic [3:0]  win;
    r16   = 16'(r);
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = {1'b0, p} + 5'(k);
      if (j >= 5'(NREQ)) j = j - 5'(NREQ);
      if (!found && r16[j[3:0]]) begin
        found = 1'b1;
        win   = j[3:0];
      end
    end
    return {found, win};
  endfunction

  function automatic logic [3:0] ptr_after(input logic [3:0] w);
    return (w == LAST) ? 4'd0 : w + 4'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      addr_a[i] = '0;
      data_a[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = req_addr[4*i +: 4];
      data_a[i] = req_data[DW*i +: DW];
    end
  end

  always_comb begin
    cur_mask = '0;
    for (int i = 0; i < NREQ; i++) cur_mask[i] = (grant_id == 4'(i));
  end

  assign pick_idle = rr_pick(req, ptr);
  assign pick_hold = rr_pick(req & ~cur_mask, ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      address  <= '0;
      wdata    <= '0;
      wclk     <= 1'b0;
      ack      <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (pick_idle[4]) begin
            address  <= addr_a[pick_idle[3:0]];
            wdata    <= data_a[pick_idle[3:0]];
            grant_id <= pick_idle[3:0];
            ptr      <= ptr_after(pick_idle[3:0]);
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          wclk  <= 1'b1;
          state <= STROBE;
        end
        STROBE: begin
          wclk  <= 1'b0;
          ack   <= cur_mask;
          state <= HOLD;
        end
        HOLD: begin
          // The finishing grantee is masked so a held req cannot win twice in a row.
          if (pick_hold[4]) begin
            address  <= addr_a[pick_hold[3:0]];
            wdata    <= data_a[pick_hold[3:0]];
            grant_id <= pick_hold[3:0];
            ptr      <= ptr_after(pick_hold[3:0]);
            state    <= SETUP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          wclk  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_write_scheduler.sv
// Directed bench for regbank_write_scheduler: transaction-level model compared every cycle,
// plus literal expectations at the key cycles of each scenario.
module tb_regbank_write_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [4*NREQ-1:0]  req_addr = '0;
  logic [DW*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]    ack;
  logic [3:0]         address;
  logic               wclk;
  logic [DW-1:0]      wdata;
  logic               busy;
  logic [3:0]         grant_id;

  regbank_write_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .address(address), .wclk(wclk), .wdata(wdata), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_cnt [NREQ];
  bit chk_on = 1'b0;
  logic prev_wclk = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: a write is three cycles (phase 1 setup, 2 strobe, 3 ack); winner chosen by
  // scanning from the pointer, skipping the just-finished grantee.
  int phase = 0, m_ptr = 0, m_gid = 0, m_addr = 0, m_data = 0, m_win;

  function automatic int pick(input logic [NREQ-1:0] r, input int p, input int excl);
    for (int k = 0; k < NREQ; k++) begin
      int w;
      w = (p + k) % NREQ;
      if (r[w] && w != excl) return w;
    end
    return -1;
  endfunction

  always_comb m_win = pick(req, m_ptr, (phase == 3) ? m_gid : -1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 0; m_ptr <= 0; m_gid <= 0; m_addr <= 0; m_data <= 0;
    end else if (phase == 1 || phase == 2) begin
      phase <= phase + 1;
    end else if (m_win >= 0) begin
      m_gid  <= m_win;
      m_addr <= int'(req_addr[4*m_win +: 4]);
      m_data <= int'(req_data[DW*m_win +: DW]);
      m_ptr  <= (m_win + 1) % NREQ;
      phase  <= 1;
    end else begin
      phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("ack",      32'(ack),      (phase == 3) ? (32'd1 << m_gid) : 32'd0);
      check("wclk",     32'(wclk),     32'(phase == 2));
      check("busy",     32'(busy),     32'(phase != 0));
      check("address",  32'(address),  32'(m_addr));
      check("wdata",    32'(wdata),    32'(m_data));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("wclk_consecutive", 32'(prev_wclk & wclk), 32'd0);
      prev_wclk = wclk;
      for (int i = 0; i < NREQ; i++) if (ack[i]) ack_cnt[i]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_wclk", 32'(wclk), 0);
    check("rst_gid",  32'(grant_id), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    logic [3:0] exp_gid [5];
    for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
    exp_gid = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    tick();
    chk_on = 1'b1;
    do_reset();
    check("rst_addr",  32'(address), 0);
    check("rst_wdata", 32'(wdata), 0);
    check("rst_ack",   32'(ack), 0);

    // Single write
    req = 4'b0100; req_addr = 16'h0A00; req_data = 32'h005C_0000;
    tick();
    check("single_addr_c1", 32'(address), 32'hA);
    check("single_wdata_c1", 32'(wdata), 32'h5C);
    check("single_wclk_c1", 32'(wclk), 0);
    tick();
    check("single_wclk_c2", 32'(wclk), 1);
    tick();
    check("single_ack_c3", 32'(ack), 32'b0100);
    check("single_wclk_c3", 32'(wclk), 0);
    req = '0;
    tick();
    check("single_busy_c4", 32'(busy), 0);
    check("single_ack_c4", 32'(ack), 0);

    // Fairness from a fresh pointer
    do_reset();
    req = 4'b1111; req_addr = 16'h4321; req_data = 32'h4030_2010;
    for (int g = 0; g < 5; g++) begin
      tick();
      check("fair_gid", 32'(grant_id), 32'(exp_gid[g]));
      check("fair_addr", 32'(address), 32'(exp_gid[g]) + 1);
      tick();
      check("fair_wclk", 32'(wclk), 1);
      tick();
      check("fair_ack", 32'(ack), 32'd1 << exp_gid[g]);
      if (g == 4) req = '0;
    end
    tick();
    check("fair_idle", 32'(busy), 0);

    // Stability: grantee changes its address during STROBE
    req = 4'b0010; req_addr = 16'h0050; req_data = 32'h0000_7700;
    tick();
    check("stab_setup_addr", 32'(address), 32'h5);
    tick();
    req_addr = 16'h00C0; req_data = 32'h0000_9900;
    tick();
    check("stab_hold_addr", 32'(address), 32'h5);
    check("stab_hold_wdata", 32'(wdata), 32'h77);
    check("stab_hold_ack", 32'(ack), 32'b0010);
    tick();
    check("stab_idle_addr", 32'(address), 32'h5);
    check("stab_idle_busy", 32'(busy), 0);
    tick();
    check("stab_regrant_addr", 32'(address), 32'hC);
    check("stab_regrant_wdata", 32'(wdata), 32'h99);
    req = '0;
    repeat (3) tick();

    // Masking: lone requester 2 holds req through ack
    c = ack_cnt[2];
    req = 4'b0100; req_addr = 16'h0300; req_data = 32'h0011_0000;
    tick();
    check("mask_gid", 32'(grant_id), 2);
    tick();
    tick();
    check("mask_ack", 32'(ack), 32'b0100);
    tick();
    check("mask_idle", 32'(busy), 0);
    tick();
    check("mask_regrant_busy", 32'(busy), 1);
    check("mask_regrant_gid", 32'(grant_id), 2);
    req = '0;
    repeat (3) tick();
    check("mask_ack_count", 32'(ack_cnt[2] - c), 2);

    // Reset while strobing
    c = ack_cnt[2];
    req = 4'b0100; req_addr = 16'h0600; req_data = 32'h00EE_0000;
    tick();
    tick();
    check("rmid_wclk_strobe", 32'(wclk), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rmid_wclk_async", 32'(wclk), 0);
    check("rmid_addr", 32'(address), 0);
    check("rmid_busy", 32'(busy), 0);
    check("rmid_wdata", 32'(wdata), 0);
    tick();
    tick();
    check("rmid_no_ack", 32'(ack_cnt[2] - c), 0);
    rst_n = 1'b1;
    req = 4'b1101; req_addr = 16'h9E07; req_data = 32'hDD00_CCAA;
    tick();
    check("rmid_first_gid", 32'(grant_id), 0);
    check("rmid_first_addr", 32'(address), 32'h7);
    check("rmid_first_wdata", 32'(wdata), 32'hAA);
    req = '0;
    repeat (4) tick();

    // Withdrawal after grant
    c = ack_cnt[1];
    req = 4'b0010; req_addr = 16'h00B0; req_data = 32'h0000_3300;
    tick();
    check("wd_gid", 32'(grant_id), 1);
    req = '0;
    tick();
    check("wd_wclk", 32'(wclk), 1);
    tick();
    check("wd_ack", 32'(ack), 32'b0010);
    tick();
    check("wd_idle", 32'(busy), 0);
    check("wd_ack_count", 32'(ack_cnt[1] - c), 1);
    tick();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
